// File: rtl/hs_fifo_pkt_reader_pkg.sv
// Shared types for the packet FIFO reader: FSM states and the header word layout.
package hs_fifo_pkt_reader_pkg;

  localparam int HDR_LEN_W = 16;
  // Header layout at the default 32-bit word / 4-bit channel configuration.
  localparam int HDR_DW    = 32;
  localparam int HDR_CW    = 4;

  typedef enum logic [1:0] {
    S_HDR,
    S_FWD,
    S_DISC
  } state_e;

  typedef struct packed {
    logic [HDR_LEN_W-1:0]               len;
    logic [HDR_DW-HDR_LEN_W-HDR_CW-1:0] reserved;
    logic [HDR_CW-1:0]                  chan;
  } pkt_hdr_t;

endpackage

// File: rtl/hs_fifo_pkt_reader_oreg.sv
// One-entry valid/ready register slice carrying a payload word, last flag and channel.
module hs_fifo_pkt_reader_oreg #(
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic [CHAN_W-1:0]     in_chan_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [CHAN_W-1:0]     out_chan_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic [CHAN_W-1:0]     chan_q;

  // Accept while empty or draining this cycle: full throughput, contents held on stall.
  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        last_q <= in_last_i;
        chan_q <= in_chan_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_chan_o  = chan_q;

endmodule

// File: rtl/hs_fifo_pkt_reader.sv
// Pops header+payload packets from the packet FIFO, filters by channel and streams
// the payload out with the channel as sideband; tracks length errors and packet counts.
module hs_fifo_pkt_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic                   rlast,
  output logic                   rpeek,
  input  logic [2**CHAN_W-1:0]   cfg_chan_en,
  output logic                   mvalid,
  input  logic                   mready,
  output logic [DATA_WIDTH-1:0]  mdata,
  output logic                   mlast,
  output logic [CHAN_W-1:0]      mchan,
  input  logic                   err_clr,
  output logic                   err_len,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   busy
);
  import hs_fifo_pkt_reader_pkg::*;

  state_e               state_q, state_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic [HDR_LEN_W-1:0] len_q, len_d, beat_q, beat_d, beat_nxt;
  logic [HDR_LEN_W-1:0] hdr_len;
  logic [CHAN_W-1:0]    hdr_chan;
  logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                 err_q, err_d, err_set;
  logic                 run_q;
  logic                 pop, o_rdy, o_vld, o_last;

  assign hdr_len  = rdata[DATA_WIDTH-1 -: HDR_LEN_W];
  assign hdr_chan = rdata[CHAN_W-1:0];
  assign beat_nxt = beat_q + HDR_LEN_W'(1);
  assign pop      = rvalid && rready;
  assign rpeek    = 1'b0;

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    len_d      = len_q;
    beat_d     = beat_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_set    = 1'b0;
    o_vld      = 1'b0;
    o_last     = 1'b0;
    // run_q keeps rready low from reset until the first clock after release.
    rready     = run_q;
    unique case (state_q)
      S_HDR: begin
        if (pop) begin
          chan_d = hdr_chan;
          len_d  = hdr_len;
          beat_d = '0;
          if (rlast) begin
            err_set    = (hdr_len != '0);
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end else if (hdr_len == '0 || !cfg_chan_en[hdr_chan]) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            state_d    = S_DISC;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            state_d   = S_FWD;
          end
        end
      end
      S_FWD: begin
        rready = run_q && o_rdy;
        if (pop) begin
          o_vld  = 1'b1;
          beat_d = beat_nxt;
          if (rlast) begin
            o_last  = 1'b1;
            err_set = (beat_nxt != len_q);
            state_d = S_HDR;
          end else if (beat_nxt == len_q) begin
            // Oversize packet: close the output packet here, drop the tail.
            o_last  = 1'b1;
            err_set = 1'b1;
            state_d = S_DISC;
          end
        end
      end
      S_DISC: begin
        if (pop && rlast) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_HDR;
      chan_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
      run_q      <= 1'b1;
    end
  end

  hs_fifo_pkt_reader_oreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHAN_W     (CHAN_W)
  ) u_oreg (
    .clk         (clk),
    .rst_n       (aresetn),
    .in_valid_i  (o_vld),
    .in_ready_o  (o_rdy),
    .in_data_i   (rdata),
    .in_last_i   (o_last),
    .in_chan_i   (chan_q),
    .out_valid_o (mvalid),
    .out_ready_i (mready),
    .out_data_o  (mdata),
    .out_last_o  (mlast),
    .out_chan_o  (mchan)
  );

  assign err_len  = err_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != S_HDR) || mvalid;

endmodule

// File: tb/tb_hs_fifo_pkt_reader.sv
// Bench for hs_fifo_pkt_reader: hand-computed packet table, corner sequences and a
// randomized phase checked against a packet-level reference model.
module tb_hs_fifo_pkt_reader;
  import hs_fifo_pkt_reader_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          rvalid = 1'b0, rready, rlast = 1'b0, rpeek;
  logic [DW-1:0] rdata = '0;
  logic [15:0]   cfg_chan_en = '1;
  logic          mvalid, mready = 1'b0, mlast;
  logic [DW-1:0] mdata;
  logic [CW-1:0] mchan;
  logic          err_clr = 1'b0, err_len, busy;
  logic [NW-1:0] pkt_cnt, drop_cnt;

  hs_fifo_pkt_reader #(.DATA_WIDTH(DW), .CHAN_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .aresetn(aresetn), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .rpeek(rpeek), .cfg_chan_en(cfg_chan_en), .mvalid(mvalid),
    .mready(mready), .mdata(mdata), .mlast(mlast), .mchan(mchan), .err_clr(err_clr),
    .err_len(err_len), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW:0]    src_q[$];   // {last, word} waiting in the FIFO
  logic [CW+DW:0] out_q[$];   // {chan, last, data} accepted downstream
  logic [CW+DW:0] exp_q[$];
  logic [DW-1:0]  pay_q[$];
  int  rv_pct = 100, mr_pct = 100;
  bit  rv_hold = 0, clr_req = 0, saw_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr_word(int len, int chan);
    pkt_hdr_t h;
    h = '0;
    h.len = 16'(len);
    h.chan = 4'(chan);
    return h;
  endfunction

  function automatic logic [CW+DW:0] mkbeat(int ch, bit last, logic [DW-1:0] d);
    return {CW'(ch), last, d};
  endfunction

  // One clock: drive at negedge, sample handshakes just before the posedge.
  task automatic step();
    @(negedge clk);
    err_clr = clr_req;
    if (src_q.size() == 0) rvalid = 1'b0;
    else if (!rv_hold) rvalid = ($urandom_range(0, 99) < rv_pct);
    if (rvalid) {rlast, rdata} = src_q[0];
    else begin rlast = 1'b0; rdata = '0; end
    mready = ($urandom_range(0, 99) < mr_pct);
    #1;
    if (err_len) saw_err = 1;
    if (mvalid && mready) out_q.push_back({mchan, mlast, mdata});
    rv_hold = rvalid && !rready;
    if (rvalid && rready) void'(src_q.pop_front());
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (!(src_q.size() == 0 && !busy) && n < 3000) begin step(); n++; end
    step(); step();
    chk({name, "_drain_timeout"}, 64'(n < 3000), 1);
  endtask

  task automatic send_pkt(int len, int chan, int n);
    logic [DW-1:0] w;
    pay_q.delete();
    src_q.push_back({(n == 0), hdr_word(len, chan)});
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      pay_q.push_back(w);
      src_q.push_back({(i == n - 1), w});
    end
  endtask

  // Packet-level reference: what leaves, what is counted, whether the length was wrong.
  int exp_pkt, exp_drop;
  bit exp_err;
  task automatic model_pkt();
    int len, n, chan, nb;
    len  = $urandom_range(0, 6);
    chan = $urandom_range(0, 15);
    n    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : len;
    send_pkt(len, chan, n);
    if (n == 0) begin
      exp_drop++;
      if (len != 0) exp_err = 1;
    end else if (len == 0 || !cfg_chan_en[chan]) begin
      exp_drop++;
    end else begin
      exp_pkt++;
      nb = (n < len) ? n : len;
      for (int i = 0; i < nb; i++) exp_q.push_back(mkbeat(chan, i == nb - 1, pay_q[i]));
      if (n != len) exp_err = 1;
    end
  endtask

  typedef struct {
    int len; int chan; int n; bit en;
    int beats; bit err; int dpkt; int ddrop;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int p0, d0, n;
    logic [DW-1:0] held;

    tbl[0] = '{3, 2, 3, 1'b1, 3, 1'b0, 1, 0};  // plain forward
    tbl[1] = '{4, 5, 4, 1'b0, 0, 1'b0, 0, 1};  // channel filtered
    tbl[2] = '{4, 1, 2, 1'b1, 2, 1'b1, 1, 0};  // truncated
    tbl[3] = '{2, 3, 5, 1'b1, 2, 1'b1, 1, 0};  // oversize tail dropped
    tbl[4] = '{1, 15, 1, 1'b1, 1, 1'b0, 1, 0}; // next packet after oversize
    tbl[5] = '{0, 2, 2, 1'b1, 0, 1'b0, 0, 1};  // zero length
    tbl[6] = '{3, 7, 0, 1'b1, 0, 1'b1, 0, 1};  // rlast on header, len!=0
    tbl[7] = '{0, 7, 0, 1'b1, 0, 1'b0, 0, 1};  // rlast on header, len==0
    tbl[8] = '{5, 0, 5, 1'b1, 5, 1'b0, 1, 0};

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rready", rready, 0);   chk("rst_mvalid", mvalid, 0);
    chk("rst_mdata", mdata, 0);     chk("rst_mlast", mlast, 0);
    chk("rst_mchan", mchan, 0);     chk("rst_err_len", err_len, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0); chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_busy", busy, 0);       chk("rst_rpeek", rpeek, 0);
    @(negedge clk); aresetn = 1'b1;
    step();

    // Table of single packets
    rv_pct = 80; mr_pct = 80;
    for (int v = 0; v < 9; v++) begin
      clr_req = 1; step(); clr_req = 0; step();
      cfg_chan_en = '1;
      if (!tbl[v].en) cfg_chan_en[tbl[v].chan] = 1'b0;
      p0 = pkt_cnt; d0 = drop_cnt; out_q.delete();
      send_pkt(tbl[v].len, tbl[v].chan, tbl[v].n);
      drain("vec");
      chk("vec_beats", out_q.size(), tbl[v].beats);
      for (int i = 0; i < out_q.size() && i < tbl[v].beats; i++)
        chk("vec_beat", out_q[i], mkbeat(tbl[v].chan, i == tbl[v].beats - 1, pay_q[i]));
      chk("vec_err_len", err_len, tbl[v].err);
      chk("vec_pkt_delta", 64'(pkt_cnt - p0), tbl[v].dpkt);
      chk("vec_drop_delta", 64'(drop_cnt - d0), tbl[v].ddrop);
    end

    // Downstream stall mid-packet
    clr_req = 1; step(); clr_req = 0; step();
    rv_pct = 100; mr_pct = 100; cfg_chan_en = '1; out_q.delete(); p0 = pkt_cnt;
    send_pkt(3, 2, 3);
    n = 0;
    while (out_q.size() < 1 && n < 50) begin step(); n++; end
    chk("stall_first_beat", out_q.size(), 1);
    mr_pct = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) held = mdata;
      chk("stall_mvalid", mvalid, 1);
      chk("stall_mdata_held", mdata, held);
      chk("stall_rready", rready, 0);
    end
    chk("stall_held_is_b", held, pay_q[1]);
    mr_pct = 100;
    drain("stall");
    chk("stall_beats", out_q.size(), 3);
    for (int i = 0; i < out_q.size() && i < 3; i++)
      chk("stall_beat", out_q[i], mkbeat(2, i == 2, pay_q[i]));
    chk("stall_err_len", err_len, 0);
    chk("stall_pkt_delta", 64'(pkt_cnt - p0), 1);

    // err_clr clears the sticky flag; a set in the same cycle as clear wins
    send_pkt(4, 1, 2);
    drain("trunc");
    chk("trunc_err_len", err_len, 1);
    clr_req = 1; step(); clr_req = 0; step();
    chk("err_clr_clears", err_len, 0);
    saw_err = 0; clr_req = 1;
    send_pkt(4, 1, 2);
    drain("setwin");
    chk("set_beats_clear", saw_err, 1);
    clr_req = 0; step(); step();
    chk("setwin_cleared_after", err_len, 0);

    // Randomized batches against the reference model
    clr_req = 1; step(); clr_req = 0; step();
    exp_err = 0; exp_pkt = 0; exp_drop = 0;
    p0 = pkt_cnt; d0 = drop_cnt; out_q.delete(); exp_q.delete();
    rv_pct = 70; mr_pct = 70;
    for (int b = 0; b < 4; b++) begin
      cfg_chan_en = 16'($urandom);
      for (int k = 0; k < 15; k++) model_pkt();
      drain("rand");
    end
    chk("rand_beats", out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk("rand_beat", out_q[i], exp_q[i]);
    chk("rand_pkt_delta", 64'(16'(pkt_cnt - p0)), 64'(16'(exp_pkt)));
    chk("rand_drop_delta", 64'(16'(drop_cnt - d0)), 64'(16'(exp_drop)));
    chk("rand_err_len", err_len, exp_err);

    // Async reset while forwarding
    cfg_chan_en = '1; rv_pct = 100; mr_pct = 0; out_q.delete();
    send_pkt(4, 2, 4);
    repeat (4) step();
    chk("prerst_mvalid", mvalid, 1);
    #2; aresetn = 1'b0; #1;
    chk("arst_mvalid", mvalid, 0);   chk("arst_rready", rready, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0); chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_busy", busy, 0);
    src_q.delete(); rv_hold = 0; rvalid = 1'b0;
    @(negedge clk); aresetn = 1'b1;
    mr_pct = 100; out_q.delete();
    send_pkt(2, 4, 2);
    drain("postrst");
    chk("postrst_beats", out_q.size(), 2);
    for (int i = 0; i < out_q.size() && i < 2; i++)
      chk("postrst_beat", out_q[i], mkbeat(4, i == 1, pay_q[i]));
    chk("postrst_pkt_cnt", pkt_cnt, 1);
    chk("postrst_drop_cnt", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
